// File: rtl/gb_bus_fabric_pkg.sv
// Shared types and constants for the Game Boy bus fabric.
package gb_bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } fabric_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Value returned to a master whose access timed out (undriven bus).
    localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

endpackage

// File: rtl/gb_bus_arbiter.sv
// Combinational request picker: scans from a start index (round-robin)
// or from index 0 (fixed priority) and returns the first requester.
module gb_bus_arbiter
    import gb_bus_fabric_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     start_i,
    input  logic                 mode_i,
    output logic [N_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    int               base;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // First requester found when walking upward from base, wrapping at N_MASTERS.
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        base     = mode_i ? int'(start_i) : 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand     = (base + k) % N_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o           = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_bus_fabric.sv
// Multi-master bus fabric: arbitrates requesters onto one downstream port,
// with lockable bursts and an optional downstream timeout.
module gb_bus_fabric
    import gb_bus_fabric_pkg::*;
#(
    parameter int N_MASTERS      = 3,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS-1:0]          m_lock,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          ds_req,
    output logic                          ds_we,
    output logic [ADDR_W-1:0]             ds_addr,
    output logic [DATA_W-1:0]             ds_wdata,
    input  logic [DATA_W-1:0]             ds_rdata,
    input  logic                          ds_ack,
    output logic [$clog2(N_MASTERS)-1:0]  grant_id,
    output logic                          busy
);

    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    fabric_state_t     state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              lock_q, lock_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    logic [IDX_W-1:0]     start_ptr;
    logic [N_MASTERS-1:0] arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 lock_hold;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_lock;
    logic                 timeout_hit;

    assign start_ptr = (last_grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : last_grant_q + 1'b1;

    gb_bus_arbiter #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_arbiter (
        .req_i   (m_req),
        .start_i (start_ptr),
        .mode_i  (ARB_MODE == ARB_RR),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // A held lock overrides arbitration only while its owner keeps requesting.
    assign lock_hold   = lock_q && m_req[grant_q];
    assign pick_valid  = lock_hold || arb_valid;
    assign pick_idx    = lock_hold ? grant_q : arb_idx;
    assign pick_lock   = lock_hold ? m_lock[grant_q] : |(arb_grant & m_lock);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic: grant and latch in IDLE, wait for downstream in ISSUE, ack in RESP.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        lock_d       = lock_q;
        tcnt_d       = tcnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = ISSUE;
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    lock_d       = pick_lock;
                    we_d         = m_we[pick_idx];
                    addr_d       = m_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d      = m_wdata[pick_idx*DATA_W +: DATA_W];
                    err_d        = 1'b0;
                    tcnt_d       = '0;
                end
            end
            ISSUE: begin
                if (ds_ack) begin
                    // Acknowledge beats a coincident timeout.
                    state_d = RESP;
                    rdata_d = ds_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = DATA_W'(OPEN_BUS_DATA);
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-command registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_MASTERS - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            lock_q       <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            lock_q       <= lock_d;
            tcnt_q       <= tcnt_d;
        end
    end

    assign ds_req   = (state_q == ISSUE);
    assign ds_we    = we_q;
    assign ds_addr  = addr_q;
    assign ds_wdata = wdata_q;
    assign m_rdata  = rdata_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_resp
        assign m_ack[gi] = (state_q == RESP) && (grant_q == IDX_W'(gi));
        assign m_err[gi] = (state_q == RESP) && (grant_q == IDX_W'(gi)) && err_q;
    end

endmodule

// File: tb/tb_gb_bus_fabric.sv
// Directed bench for gb_bus_fabric: a fixed-priority instance with a
// 4-cycle timeout and a round-robin instance without timeout.
module tb_gb_bus_fabric;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Instance A: fixed priority, TIMEOUT_CYCLES = 4
    logic [2:0]  a_m_req, a_m_we, a_m_lock, a_m_ack, a_m_err;
    logic [47:0] a_m_addr;
    logic [23:0] a_m_wdata;
    logic [7:0]  a_m_rdata, a_ds_wdata, a_ds_rdata;
    logic        a_ds_req, a_ds_we, a_ds_ack, a_busy, a_auto, a_manual;
    logic [15:0] a_ds_addr;
    logic [1:0]  a_grant_id;

    // Instance B: round-robin, timeout disabled
    logic [2:0]  b_m_req, b_m_we, b_m_lock, b_m_ack, b_m_err;
    logic [47:0] b_m_addr;
    logic [23:0] b_m_wdata;
    logic [7:0]  b_m_rdata, b_ds_wdata, b_ds_rdata;
    logic        b_ds_req, b_ds_we, b_ds_ack, b_busy, b_auto;
    logic [15:0] b_ds_addr;
    logic [1:0]  b_grant_id;

    // Downstream models: zero-wait ack when auto is set, or a manual pulse.
    assign a_ds_ack = (a_ds_req & a_auto) | a_manual;
    assign b_ds_ack = b_ds_req & b_auto;

    gb_bus_fabric #(
        .N_MASTERS(3), .ADDR_W(16), .DATA_W(8), .ARB_MODE(0), .TIMEOUT_CYCLES(4)
    ) u_fix (
        .clk(clk), .reset(reset),
        .m_req(a_m_req), .m_we(a_m_we), .m_lock(a_m_lock),
        .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_ack(a_m_ack), .m_err(a_m_err), .m_rdata(a_m_rdata),
        .ds_req(a_ds_req), .ds_we(a_ds_we), .ds_addr(a_ds_addr), .ds_wdata(a_ds_wdata),
        .ds_rdata(a_ds_rdata), .ds_ack(a_ds_ack),
        .grant_id(a_grant_id), .busy(a_busy)
    );

    gb_bus_fabric #(
        .N_MASTERS(3), .ADDR_W(16), .DATA_W(8), .ARB_MODE(1), .TIMEOUT_CYCLES(0)
    ) u_rr (
        .clk(clk), .reset(reset),
        .m_req(b_m_req), .m_we(b_m_we), .m_lock(b_m_lock),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_ack(b_m_ack), .m_err(b_m_err), .m_rdata(b_m_rdata),
        .ds_req(b_ds_req), .ds_we(b_ds_we), .ds_addr(b_ds_addr), .ds_wdata(b_ds_wdata),
        .ds_rdata(b_ds_rdata), .ds_ack(b_ds_ack),
        .grant_id(b_grant_id), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            miss_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=0x%0h expected=0x%0h", vec_cnt, tag, obs, exp);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        a_m_req    = '0; a_m_we = '0; a_m_lock = '0;
        a_m_addr   = {16'hFF80, 16'hC001, 16'h1000};
        a_m_wdata  = {8'h33, 8'hA7, 8'h11};
        a_ds_rdata = 8'h5A; a_auto = 1'b1; a_manual = 1'b0;
        b_m_req    = '0; b_m_we = '0; b_m_lock = '0;
        b_m_addr   = {16'h2222, 16'h1111, 16'h0000};
        b_m_wdata  = '0;
        b_ds_rdata = 8'h77; b_auto = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy",    32'(a_busy),     32'h0);
        check("rst_ds_req",  32'(a_ds_req),   32'h0);
        check("rst_m_ack",   32'(a_m_ack),    32'h0);
        check("rst_m_err",   32'(a_m_err),    32'h0);
        check("rst_grant",   32'(a_grant_id), 32'h0);
        check("rst_ds_addr", 32'(a_ds_addr),  32'h0);
        check("rst_ds_we",   32'(a_ds_we),    32'h0);
        check("rst_rdata",   32'(a_m_rdata),  32'h0);

        // Fixed priority: masters 1 (write) and 2 request together
        a_m_we  = 3'b010;
        a_m_req = 3'b110;
        tick();
        check("fix_grant1",  32'(a_grant_id), 32'h1);
        check("fix_dsreq1",  32'(a_ds_req),   32'h1);
        check("fix_addr1",   32'(a_ds_addr),  32'hC001);
        check("fix_we1",     32'(a_ds_we),    32'h1);
        check("fix_wdata1",  32'(a_ds_wdata), 32'hA7);
        tick();
        check("fix_ack1",    32'(a_m_ack),    32'h2);
        check("fix_err1",    32'(a_m_err),    32'h0);
        check("fix_rdata1",  32'(a_m_rdata),  32'h5A);
        check("fix_dsreq_r", 32'(a_ds_req),   32'h0);
        a_m_req = 3'b100;
        tick();
        check("fix_idle",    32'(a_busy),     32'h0);
        check("fix_noack",   32'(a_m_ack),    32'h0);
        tick();
        check("fix_grant2",  32'(a_grant_id), 32'h2);
        check("fix_addr2",   32'(a_ds_addr),  32'hFF80);
        check("fix_we2",     32'(a_ds_we),    32'h0);
        tick();
        check("fix_ack2",    32'(a_m_ack),    32'h4);
        a_m_req = 3'b000;
        a_m_we  = 3'b000;
        tick();

        // Stray ds_ack while idle is ignored
        a_manual = 1'b1;
        tick();
        a_manual = 1'b0;
        check("stray_busy",  32'(a_busy),     32'h0);
        tick();
        check("stray_ack",   32'(a_m_ack),    32'h0);

        // Locked 4-read burst by master 2 while master 0 requests
        for (int i = 0; i < 4; i++) begin
            a_m_lock = (i < 3) ? 3'b100 : 3'b000;
            a_m_req  = (i == 0) ? 3'b100 : 3'b101;
            tick();
            check($sformatf("lock_grant%0d", i), 32'(a_grant_id), 32'h2);
            tick();
            check($sformatf("lock_ack%0d", i), 32'(a_m_ack), 32'h4);
            tick();
        end
        a_m_lock = 3'b000;
        a_m_req  = 3'b001;
        tick();
        check("lock_after",  32'(a_grant_id), 32'h0);
        tick();
        check("lock_after_ack", 32'(a_m_ack), 32'h1);
        a_m_req = 3'b000;
        tick();

        // Timeout: ds_ack never arrives
        a_auto  = 1'b0;
        a_m_req = 3'b001;
        tick();
        n = 0;
        while (a_ds_req && n < 10) begin
            n++;
            tick();
        end
        check("to_dsreq_cycles", 32'(n),      32'd4);
        check("to_ack",      32'(a_m_ack),    32'h1);
        check("to_err",      32'(a_m_err),    32'h1);
        check("to_rdata",    32'(a_m_rdata),  32'hFF);
        a_m_req = 3'b000;
        tick();

        // ds_ack on the timeout cycle wins
        a_ds_rdata = 8'h3C;
        a_m_req    = 3'b001;
        tick();
        tick();
        tick();
        tick();
        check("tie_dsreq",   32'(a_ds_req),   32'h1);
        a_manual = 1'b1;
        tick();
        a_manual = 1'b0;
        check("tie_ack",     32'(a_m_ack),    32'h1);
        check("tie_err",     32'(a_m_err),    32'h0);
        check("tie_rdata",   32'(a_m_rdata),  32'h3C);
        a_m_req = 3'b000;
        tick();

        // Round-robin with all three requesting continuously
        b_m_req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), 32'(b_grant_id), 32'(i % 3));
            tick();
            check($sformatf("rr_ack%0d", i), 32'(b_m_ack), 32'(1 << (i % 3)));
            tick();
        end

        // Reset while in ISSUE aborts the transaction and restarts round-robin
        tick();
        tick();
        tick();
        b_auto = 1'b0;
        tick();
        check("rst_mid_grant", 32'(b_grant_id), 32'h1);
        check("rst_mid_dsreq", 32'(b_ds_req),   32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_dsreq0", 32'(b_ds_req),  32'h0);
        check("rst_mid_busy0",  32'(b_busy),    32'h0);
        check("rst_mid_noack",  32'(b_m_ack),   32'h0);
        b_auto = 1'b1;
        tick();
        check("rst_rr_restart", 32'(b_grant_id), 32'h0);
        tick();
        check("rst_rr_ack",     32'(b_m_ack),    32'h1);
        b_m_req = 3'b000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
